trap_ctrl: RTL and testbench

- Machine-mode trap sequencer that sits directly upstream of the csr block.
- Detects ecall/ebreak/mret from EX stage and the machine timer interrupt.
- Holds the pipeline while it writes mepc, mcause and mstatus through csr's single write port, one register per cycle.
- Redirects the PC to the trap vector or to mepc.

---
 rtl/trap_ctrl_pkg.sv | 53 +++++
 rtl/trap_ctrl_if.sv | 37 +++
 rtl/trap_vec_calc.sv | 30 +++
 rtl/trap_ctrl.sv | 122 ++++++++++++
 tb/tb_trap_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
// trap_ctrl_pkg : CSR addresses, cause codes, mstatus fields, FSM encoding
// Revision      : 1.0
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_W_MEPC         = 3'd1,
    S_W_MCAUSE       = 3'd2,
    S_W_MSTATUS      = 3'd3,
    S_W_MSTATUS_MRET = 3'd4,
    S_JUMP           = 3'd5
  } trap_state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_if.sv
// ============================================================================
// trap_ctrl_if : EX-stage requests, CSR read/write and PC redirect signals
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface trap_ctrl_if;
  logic        inst_ecall_i;
  logic        inst_ebreak_i;
  logic        inst_mret_i;
  logic [31:0] inst_addr_i;
  logic        irq_timer_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;

  modport slave (
    input  inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i, irq_timer_i,
           mtvec_i, mepc_i, mstatus_i, mie_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_flag_o, jump_addr_o
  );

  modport master (
    output inst_ecall_i, inst_ebreak_i, inst_mret_i, inst_addr_i, irq_timer_i,
           mtvec_i, mepc_i, mstatus_i, mie_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, jump_flag_o, jump_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/trap_vec_calc.sv
// ============================================================================
// trap_vec_calc : trap target from mtvec; TRAP_VECTORED_EN adds irq vectoring
// Revision      : 1.0
// ============================================================================
`default_nettype none

module trap_vec_calc (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  input  logic        is_irq,
  output logic [31:0] target
);

  logic [31:0] base;
  logic        unused_bits;

  assign base = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Interrupts in vectored mode land at base + 4*code; exceptions never do.
  assign target      = (is_irq && (mtvec[1:0] == 2'b01)) ? (base + {cause[29:0], 2'b00}) : base;
  assign unused_bits = ^cause[31:30];
`else
  assign target      = base;
  assign unused_bits = ^{mtvec[1:0], cause, is_irq};
`endif

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// trap_ctrl : M-mode trap sequencer, writes mepc/mcause/mstatus then redirects
//             (optional TRAP_VECTORED_EN enables vectored interrupt targets)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          CAUSE_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);

  trap_state_e        state;
  logic [CAUSE_W-1:0] cause;
  logic               is_irq;
  logic [31:0]        ret_addr;

  logic        we_q;
  logic [11:0] waddr_q;
  logic [31:0] wdata_q;
  logic        jflag_q;
  logic [31:0] jaddr_q;

  logic        irq_ok;
  logic        trap_req;
  logic        accept;
  logic [31:0] trap_target;
  logic        unused_mie;

  assign irq_ok   = bus.irq_timer_i & bus.mstatus_i[MSTATUS_MIE] & bus.mie_i[MIE_MTIE];
  assign trap_req = bus.inst_ecall_i | bus.inst_ebreak_i | (~bus.inst_mret_i & irq_ok);
  assign accept   = (state == S_IDLE) & (trap_req | bus.inst_mret_i);

  // Stall must already cover the accept cycle, before the FSM has moved.
  assign bus.hold_o      = ~rst & (accept | (state != S_IDLE));
  assign bus.csr_we_o    = we_q;
  assign bus.csr_waddr_o = waddr_q;
  assign bus.csr_wdata_o = wdata_q;
  assign bus.jump_flag_o = jflag_q;
  assign bus.jump_addr_o = jaddr_q;

  assign unused_mie = ^{bus.mie_i[31:MIE_MTIE+1], bus.mie_i[MIE_MTIE-1:0]};

  trap_vec_calc u_vec (
    .mtvec  (bus.mtvec_i),
    .cause  (cause),
    .is_irq (is_irq),
    .target (trap_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cause    <= '0;
      is_irq   <= 1'b0;
      ret_addr <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      jflag_q  <= 1'b0;
      jaddr_q  <= RESET_VEC;
    end else begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      jflag_q <= 1'b0;
      jaddr_q <= RESET_VEC;
      case (state)
        S_IDLE: begin
          if (trap_req) begin
            state   <= S_W_MEPC;
            is_irq  <= ~bus.inst_ecall_i & ~bus.inst_ebreak_i;
            cause   <= bus.inst_ecall_i  ? CAUSE_ECALL_M :
                       bus.inst_ebreak_i ? CAUSE_BREAKPOINT : CAUSE_M_TIMER_IRQ;
            we_q    <= 1'b1;
            waddr_q <= CSR_MEPC;
            wdata_q <= bus.inst_addr_i;
          end else if (bus.inst_mret_i) begin
            state    <= S_W_MSTATUS_MRET;
            ret_addr <= bus.mepc_i;
            we_q     <= 1'b1;
            waddr_q  <= CSR_MSTATUS;
            wdata_q  <= mstatus_on_mret(bus.mstatus_i);
          end
        end
        S_W_MEPC: begin
          state   <= S_W_MCAUSE;
          we_q    <= 1'b1;
          waddr_q <= CSR_MCAUSE;
          wdata_q <= cause;
        end
        S_W_MCAUSE: begin
          state   <= S_W_MSTATUS;
          we_q    <= 1'b1;
          waddr_q <= CSR_MSTATUS;
          wdata_q <= mstatus_on_trap(bus.mstatus_i);
        end
        S_W_MSTATUS: begin
          state   <= S_JUMP;
          jflag_q <= 1'b1;
          jaddr_q <= trap_target;
        end
        S_W_MSTATUS_MRET: begin
          state   <= S_JUMP;
          jflag_q <= 1'b1;
          jaddr_q <= ret_addr;
        end
        S_JUMP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// tb_trap_ctrl : cycle-by-cycle vector table with an expected-output queue
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

  typedef struct {
    logic        rst, ecall, ebreak, mret, irq;
    logic [31:0] pc, mtvec, mepc, mstatus, mie;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        hold, jflag;
    logic [31:0] jaddr;
  } vec_t;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_TGT = 32'h0000_021C;
`else
  localparam logic [31:0] IRQ_TGT = 32'h0000_0200;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  trap_ctrl_if tif();

  trap_ctrl #(.RESET_VEC(32'h0000_0000), .CAUSE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, e, b, m, i,
                              input logic [31:0] pc, tv, ep, st, ie,
                              input logic we, input logic [11:0] wa,
                              input logic [31:0] wd, input logic h, j,
                              input logic [31:0] ja);
    vec_t v;
    v.rst = r; v.ecall = e; v.ebreak = b; v.mret = m; v.irq = i;
    v.pc = pc; v.mtvec = tv; v.mepc = ep; v.mstatus = st; v.mie = ie;
    v.we = we; v.waddr = wa; v.wdata = wd; v.hold = h; v.jflag = j; v.jaddr = ja;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, want);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    rst                = v.rst;
    tif.inst_ecall_i   = v.ecall;
    tif.inst_ebreak_i  = v.ebreak;
    tif.inst_mret_i    = v.mret;
    tif.irq_timer_i    = v.irq;
    tif.inst_addr_i    = v.pc;
    tif.mtvec_i        = v.mtvec;
    tif.mepc_i         = v.mepc;
    tif.mstatus_i      = v.mstatus;
    tif.mie_i          = v.mie;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("csr_we",    idx, {31'd0, tif.csr_we_o},    {31'd0, e.we});
    chk("csr_waddr", idx, {20'd0, tif.csr_waddr_o}, {20'd0, e.waddr});
    chk("csr_wdata", idx, tif.csr_wdata_o,          e.wdata);
    chk("hold",      idx, {31'd0, tif.hold_o},      {31'd0, e.hold});
    chk("jump_flag", idx, {31'd0, tif.jump_flag_o}, {31'd0, e.jflag});
    chk("jump_addr", idx, tif.jump_addr_o,          e.jaddr);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tif.inst_ecall_i = 1'b1; tif.inst_ebreak_i = 1'b0; tif.inst_mret_i = 1'b0;
    tif.irq_timer_i = 1'b0; tif.inst_addr_i = 32'h100; tif.mtvec_i = 32'h200;
    tif.mepc_i = '0; tif.mstatus_i = 32'h8; tif.mie_i = '0;

    // Reset held with a pending ecall
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  0,12'h0,0,0,0,0));
    // ECALL, request held high while stalled
    tbl.push_back(mk(0,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  0,12'h000,0,            1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  1,12'h341,32'h100,      1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  1,12'h342,32'd11,       1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  1,12'h300,32'h1880,     1,0,0));
    tbl.push_back(mk(0,1,0,0,0, 32'h100,32'h200,0,32'h8,0,  0,12'h000,0,            1,1,32'h200));
    tbl.push_back(mk(0,0,0,0,0, 32'h104,32'h200,0,32'h8,0,  0,12'h000,0,            0,0,0));
    // MRET
    tbl.push_back(mk(0,0,0,1,0, 32'h200,32'h200,32'h104,32'h1880,0, 0,12'h000,0,        1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h200,32'h200,32'h104,32'h1880,0, 1,12'h300,32'h1888, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 32'h200,32'h200,32'h104,32'h1880,0, 0,12'h000,0,        1,1,32'h104));
    tbl.push_back(mk(0,0,0,0,0, 32'h104,32'h200,32'h104,32'h1888,0, 0,12'h000,0,        0,0,0));
    // Timer interrupt, vectored mtvec
    tbl.push_back(mk(0,0,0,0,1, 32'h180,32'h201,0,32'h8,32'h80, 0,12'h000,0,            1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h180,32'h201,0,32'h8,32'h80, 1,12'h341,32'h180,      1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h180,32'h201,0,32'h8,32'h80, 1,12'h342,32'h8000_0007,1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h180,32'h201,0,32'h8,32'h80, 1,12'h300,32'h1880,     1,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h180,32'h201,0,32'h8,32'h80, 0,12'h000,0,            1,1,IRQ_TGT));
    tbl.push_back(mk(0,0,0,0,0, 32'h180,32'h201,0,32'h8,32'h80, 0,12'h000,0,            0,0,0));
    // Masked interrupt: MIE clear, then MTIE clear
    tbl.push_back(mk(0,0,0,0,1, 32'h184,32'h200,0,32'h0,32'h80, 0,12'h000,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h184,32'h200,0,32'h0,32'h80, 0,12'h000,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 32'h184,32'h200,0,32'h8,32'h00, 0,12'h000,0,            0,0,0));
    // ecall + ebreak + irq together: ecall wins
    tbl.push_back(mk(0,1,1,0,1, 32'h140,32'h200,0,32'h8,32'h80, 0,12'h000,0,            1,0,0));
    tbl.push_back(mk(0,1,1,0,1, 32'h140,32'h200,0,32'h8,32'h80, 1,12'h341,32'h140,      1,0,0));
    tbl.push_back(mk(0,1,1,0,1, 32'h140,32'h200,0,32'h8,32'h80, 1,12'h342,32'd11,       1,0,0));
    tbl.push_back(mk(0,1,1,0,1, 32'h140,32'h200,0,32'h8,32'h80, 1,12'h300,32'h1880,     1,0,0));
    tbl.push_back(mk(0,1,1,0,1, 32'h140,32'h200,0,32'h8,32'h80, 0,12'h000,0,            1,1,32'h200));
    tbl.push_back(mk(0,0,0,0,0, 32'h144,32'h200,0,32'h8,32'h80, 0,12'h000,0,            0,0,0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], i);

    // Reset during W_MCAUSE, then an ebreak runs a full sequence (base target even if vectored)
    step(mk(0,1,0,0,0, 32'h300,32'h200,0,32'h8,0, 0,12'h000,0,        1,0,0), 100);
    step(mk(0,1,0,0,0, 32'h300,32'h200,0,32'h8,0, 1,12'h341,32'h300,  1,0,0), 101);
    step(mk(1,1,0,0,0, 32'h300,32'h200,0,32'h8,0, 1,12'h342,32'd11,   0,0,0), 102);
    step(mk(0,0,0,0,0, 32'h300,32'h200,0,32'h8,0, 0,12'h000,0,        0,0,0), 103);
    step(mk(0,0,1,0,0, 32'h3C0,32'h201,0,32'h8,0, 0,12'h000,0,        1,0,0), 104);
    step(mk(0,0,1,0,0, 32'h3C0,32'h201,0,32'h8,0, 1,12'h341,32'h3C0,  1,0,0), 105);
    step(mk(0,0,1,0,0, 32'h3C0,32'h201,0,32'h8,0, 1,12'h342,32'd3,    1,0,0), 106);
    step(mk(0,0,1,0,0, 32'h3C0,32'h201,0,32'h8,0, 1,12'h300,32'h1880, 1,0,0), 107);
    step(mk(0,0,1,0,0, 32'h3C0,32'h201,0,32'h8,0, 0,12'h000,0,        1,1,32'h200), 108);
    step(mk(0,0,0,0,0, 32'h3C4,32'h201,0,32'h8,0, 0,12'h000,0,        0,0,0), 109);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
